// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider, q = (a << FRAC) / b, one restoring quotient bit per clock.
// Results truncate toward zero and saturate to the WIDTH-bit signed range; b == 0 saturates and is flagged.
module fixed_point_divider #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             valid_in,
   output logic             ready_out,
   output logic [WIDTH-1:0] q_out,
   output logic             valid_out,
   output logic             overflow_out,
   output logic             div_zero_out,
   output logic [1:0]       dbg_state_out
);

   localparam int ITER = WIDTH + FRAC;
   localparam int CW   = $clog2(ITER);

   localparam logic [WIDTH-1:0] Q_MAX       = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] Q_MIN       = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [ITER-1:0]  MAG_POS_LIM = {{(ITER-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [ITER-1:0]  MAG_NEG_LIM = {{(ITER-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [ITER-1:0]  dvd_q;
   logic [WIDTH:0]   rem_q;
   logic [ITER-1:0]  quo_q;
   logic [WIDTH-1:0] bmag_q;
   logic [CW-1:0]    cnt_q;
   logic             sign_q;
   logic             bzero_q;
   logic [WIDTH-1:0] q_q;
   logic             valid_q;
   logic             ovf_q;
   logic             dz_q;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH+1:0] rem_sh;
   logic             rem_ge;
   logic [WIDTH:0]   rem_d;
   logic [ITER-1:0]  quo_d;
   logic [WIDTH-1:0] q_d;
   logic             ovf_d;

   // Magnitudes are WIDTH-bit unsigned, so the most negative operand is represented exactly.
   always_comb begin
      a_mag = a_in[WIDTH-1] ? -a_in : a_in;
      b_mag = b_in[WIDTH-1] ? -b_in : b_in;
   end

   always_comb begin
      rem_sh = {rem_q, dvd_q[ITER-1]};
      rem_ge = (rem_sh >= {2'b00, bmag_q});
      rem_d  = rem_ge ? (WIDTH+1)'(rem_sh - {2'b00, bmag_q}) : rem_sh[WIDTH:0];
      quo_d  = {quo_q[ITER-2:0], rem_ge};
   end

   // With b == 0 the sign bit equals the sign of a, which picks the saturation rail.
   always_comb begin
      q_d   = quo_q[WIDTH-1:0];
      ovf_d = 1'b0;
      if (bzero_q) begin
         q_d   = sign_q ? Q_MIN : Q_MAX;
         ovf_d = 1'b1;
      end else if (sign_q) begin
         if (quo_q > MAG_NEG_LIM) begin
            q_d   = Q_MIN;
            ovf_d = 1'b1;
         end else begin
            q_d = -quo_q[WIDTH-1:0];
         end
      end else if (quo_q > MAG_POS_LIM) begin
         q_d   = Q_MAX;
         ovf_d = 1'b1;
      end
   end

   // Handshake: operands transfer on a clock edge where valid_in && ready_out; ready_out is high
   // only in IDLE, valid_in is ignored otherwise, and valid_out is a single-cycle result pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         dvd_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         bmag_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         bzero_q <= 1'b0;
         q_q     <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  dvd_q   <= {a_mag, {FRAC{1'b0}}};
                  rem_q   <= '0;
                  quo_q   <= '0;
                  bmag_q  <= b_mag;
                  sign_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                  bzero_q <= (b_in == '0);
                  cnt_q   <= CW'(ITER - 1);
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               rem_q <= rem_d;
               quo_q <= quo_d;
               dvd_q <= {dvd_q[ITER-2:0], 1'b0};
               if (cnt_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_DONE: begin
               q_q     <= q_d;
               ovf_q   <= ovf_d;
               dz_q    <= bzero_q;
               valid_q <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_out     = (state_q == S_IDLE);
   assign q_out         = q_q;
   assign valid_out     = valid_q;
   assign overflow_out  = ovf_q;
   assign div_zero_out  = dz_q;
   assign dbg_state_out = state_q;

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: hand-computed Q2.14 quotients, flags, latency, abort and back-to-back.
module tb_fixed_point_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a_in;
   logic [15:0] b_in;
   logic        valid_in;
   logic        ready_out;
   logic [15:0] q_out;
   logic        valid_out;
   logic        overflow_out;
   logic        div_zero_out;
   logic [1:0]  dbg_state_out;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fixed_point_divider dut (
      .clk           (clk),
      .rst           (rst),
      .a_in          (a_in),
      .b_in          (b_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .q_out         (q_out),
      .valid_out     (valid_out),
      .overflow_out  (overflow_out),
      .div_zero_out  (div_zero_out),
      .dbg_state_out (dbg_state_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, output int at_cyc, output bit seen);
      seen   = 1'b0;
      at_cyc = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         tick();
         if (valid_out === 1'b1) begin
            seen   = 1'b1;
            at_cyc = cyc;
         end
      end
      total++;
      assert (seen) else begin
         bad++;
         $error("FAIL %s_timeout: observed no valid_out expected valid_out within 100 cycles", tag);
      end
   endtask

   task automatic divide(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_q, input logic exp_ovf, input logic exp_dz);
      int  acc;
      int  vc;
      bit  seen;
      a_in     = a;
      b_in     = b;
      valid_in = 1'b1;
      acc      = cyc;
      tick();
      valid_in = 1'b0;
      check({tag, "_busy_ready"}, 16'(ready_out), 16'd0);
      wait_valid(tag, vc, seen);
      if (seen) begin
         check({tag, "_q"},       q_out, exp_q);
         check({tag, "_ovf"},     16'(overflow_out), 16'(exp_ovf));
         check({tag, "_dz"},      16'(div_zero_out), 16'(exp_dz));
         check({tag, "_latency"}, 16'(vc - acc), 16'd32);
         check({tag, "_ready"},   16'(ready_out), 16'd1);
         tick();
         check({tag, "_pulse"},   16'(valid_out), 16'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acc;
      int  vc;
      int  nvalid;
      bit  seen;

      rst      = 1'b1;
      valid_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      tick();
      tick();
      check("rst_ready", 16'(ready_out), 16'd1);
      check("rst_q",     q_out, 16'h0000);
      check("rst_valid", 16'(valid_out), 16'd0);
      check("rst_ovf",   16'(overflow_out), 16'd0);
      check("rst_dz",    16'(div_zero_out), 16'd0);
      check("rst_state", 16'(dbg_state_out), 16'd0);
      rst = 1'b0;
      tick();

      divide("half",      16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0);
      divide("third",     16'h1000, 16'h3000, 16'h1555, 1'b0, 1'b0);
      divide("neg_third", 16'hF000, 16'h3000, 16'hEAAB, 1'b0, 1'b0);
      divide("pos_sat",   16'h4000, 16'h2000, 16'h7FFF, 1'b1, 1'b0);
      divide("neg_sat",   16'hC000, 16'h1000, 16'h8000, 1'b1, 1'b0);
      divide("exact_min", 16'h8000, 16'h4000, 16'h8000, 1'b0, 1'b0);
      divide("dz_pos",    16'h2000, 16'h0000, 16'h7FFF, 1'b1, 1'b1);
      divide("dz_neg",    16'hE000, 16'h0000, 16'h8000, 1'b1, 1'b1);
      divide("zero_num",  16'h0000, 16'h3000, 16'h0000, 1'b0, 1'b0);
      divide("neg_div",   16'h2000, 16'hC000, 16'hE000, 1'b0, 1'b0);
      divide("both_neg",  16'hF000, 16'hD000, 16'h1555, 1'b0, 1'b0);
      divide("mul_inv",   16'h39C1, 16'h3CCC, 16'h3CCB, 1'b0, 1'b0);

      tick();
      tick();
      check("hold_q",   q_out, 16'h3CCB);
      check("hold_ovf", 16'(overflow_out), 16'd0);

      // Abort a divide 10 cycles into BUSY.
      a_in     = 16'h4000;
      b_in     = 16'h2000;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("abort_busy_state", 16'(dbg_state_out), 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 16'(ready_out), 16'd1);
      check("abort_q",     q_out, 16'h0000);
      check("abort_valid", 16'(valid_out), 16'd0);
      check("abort_ovf",   16'(overflow_out), 16'd0);
      nvalid = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (valid_out === 1'b1) nvalid++;
      end
      check("abort_no_valid", 16'(nvalid), 16'd0);

      // valid_in held through BUSY, then a back-to-back accept in the result cycle.
      a_in     = 16'h1000;
      b_in     = 16'h3000;
      valid_in = 1'b1;
      acc      = cyc;
      tick();
      a_in = 16'h4000;
      b_in = 16'h2000;
      tick();
      check("b2b_busy_ready", 16'(ready_out), 16'd0);
      wait_valid("b2b_first", vc, seen);
      if (seen) begin
         check("b2b_first_q",       q_out, 16'h1555);
         check("b2b_first_ovf",     16'(overflow_out), 16'd0);
         check("b2b_first_latency", 16'(vc - acc), 16'd32);
         acc = cyc;
         tick();
         valid_in = 1'b0;
         check("b2b_accepted", 16'(ready_out), 16'd0);
         wait_valid("b2b_second", vc, seen);
         if (seen) begin
            check("b2b_second_q",       q_out, 16'h7FFF);
            check("b2b_second_ovf",     16'(overflow_out), 16'd1);
            check("b2b_second_dz",      16'(div_zero_out), 16'd0);
            check("b2b_second_latency", 16'(vc - acc), 16'd32);
         end
      end
      valid_in = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
